// File: rtl/disp_pkg.sv
// Shared display-side definitions: arbiter state encoding, BCD word packing, board timing.
package disp_pkg;
  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 4;
  localparam int BCD_W   = DIGIT_W * DIGITS;

  localparam int unsigned    CYCLES_PER_MS = 100000;
  localparam logic [DIGIT_W-1:0] IDLE_CODE_DEF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;
endpackage

// File: rtl/hold_timer.sv
// 32-bit saturating ownership timer; expired once the count reaches HOLD_CYCLES-1.
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_expired
);
  localparam logic [31:0] LAST = 32'(HOLD_CYCLES - 1);

  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)               r_cnt <= '0;
    else if (i_clr)        r_cnt <= '0;
    else if (r_cnt != LAST) r_cnt <= r_cnt + 32'd1;
  end

  assign o_expired = (r_cnt == LAST);
endmodule

// File: rtl/display_arbiter.sv
// Two-requester arbiter for the 4-digit display with minimum hold time.
// Define DISP_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module display_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned         CYCLES_PER_MS = disp_pkg::CYCLES_PER_MS,
  parameter int unsigned         HOLD_MS       = 500,
  parameter logic [DIGIT_W-1:0]  IDLE_CODE     = IDLE_CODE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [BCD_W-1:0]   data0,
  input  logic               req1,
  input  logic [BCD_W-1:0]   data1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [DIGIT_W-1:0] bcd0,
  output logic [DIGIT_W-1:0] bcd1,
  output logic [DIGIT_W-1:0] bcd2,
  output logic [DIGIT_W-1:0] bcd3
);
  localparam int unsigned HOLD_CYCLES = CYCLES_PER_MS * HOLD_MS;

`ifdef DISP_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  arb_state_t       r_state, w_nxt;
  logic             r_last;
  logic             w_expired, w_enter;
  logic [BCD_W-1:0] r_bcd, w_bcd;

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_enter),
    .o_expired (w_expired)
  );

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (req0 && req1) w_nxt = (FIXED_PRIO || r_last) ? ST_OWN0 : ST_OWN1;
        else if (req0)    w_nxt = ST_OWN0;
        else if (req1)    w_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        // Dropping the request ignores the hold; preemption waits for it.
        if (!req0)                            w_nxt = req1 ? ST_OWN1 : ST_IDLE;
        else if (w_expired && req1 && !FIXED_PRIO) w_nxt = ST_OWN1;
      end
      ST_OWN1: begin
        if (!req1)                 w_nxt = req0 ? ST_OWN0 : ST_IDLE;
        else if (w_expired && req0) w_nxt = ST_OWN0;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign w_enter = (w_nxt != r_state) && (w_nxt != ST_IDLE);

  always_comb begin
    w_bcd = {DIGITS{IDLE_CODE}};
    if (w_nxt == ST_OWN0)      w_bcd = data0;
    else if (w_nxt == ST_OWN1) w_bcd = data1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      r_bcd   <= {DIGITS{IDLE_CODE}};
    end else begin
      r_state <= w_nxt;
      if (w_enter) r_last <= (w_nxt == ST_OWN1);
      gnt0    <= (w_nxt == ST_OWN0);
      gnt1    <= (w_nxt == ST_OWN1);
      r_bcd   <= w_bcd;
    end
  end

  assign bcd0 = r_bcd[0*DIGIT_W +: DIGIT_W];
  assign bcd1 = r_bcd[1*DIGIT_W +: DIGIT_W];
  assign bcd2 = r_bcd[2*DIGIT_W +: DIGIT_W];
  assign bcd3 = r_bcd[3*DIGIT_W +: DIGIT_W];
endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: directed scenarios plus random traffic vs. an ownership model.
module tb_display_arbiter;
  localparam int H = 4;
`ifdef DISP_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req0, req1;
  logic [15:0] data0, data1;
  logic        gnt0, gnt1;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3;

  display_arbiter #(.CYCLES_PER_MS(1), .HOLD_MS(4), .IDLE_CODE(4'hF)) dut (
    .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic [15:0] bcd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Ownership model: who owns, how long they've held, who was served last.
  int m_owner = -1;
  int m_age   = 0;
  int m_last  = 1;

  task automatic step(input logic r, input logic a, input logic [15:0] da,
                      input logic b, input logic [15:0] db);
    int   nxt;
    logic rq[2];
    exp_t e;
    @(negedge clk);
    rst = r; req0 = a; req1 = b; data0 = da; data1 = db;
    rq[0] = a; rq[1] = b;
    if (r) begin
      m_owner = -1; m_age = 0; m_last = 1;
    end else begin
      nxt = m_owner;
      if (m_owner < 0) begin
        if (a && b)  nxt = FIXED ? 0 : 1 - m_last;
        else if (a)  nxt = 0;
        else if (b)  nxt = 1;
      end else if (!rq[m_owner]) begin
        nxt = rq[1-m_owner] ? 1 - m_owner : -1;
      end else if (m_age >= H-1 && rq[1-m_owner] && (!FIXED || m_owner == 1)) begin
        nxt = 1 - m_owner;
      end
      if (nxt >= 0 && nxt != m_owner) begin
        m_age = 0; m_last = nxt;
      end else if (m_age < H-1) begin
        m_age++;
      end
      m_owner = nxt;
    end
    e.g0  = (m_owner == 0);
    e.g1  = (m_owner == 1);
    e.bcd = (m_owner == 0) ? da : (m_owner == 1) ? db : 16'hFFFF;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({gnt0, gnt1, bcd3, bcd2, bcd1, bcd0} !== e) begin
          errors++;
          $display("FAIL out cyc=%0d got gnt=%b%b bcd=%h%h%h%h exp gnt=%b%b bcd=%h",
                   cyc, gnt0, gnt1, bcd3, bcd2, bcd1, bcd0, e.g0, e.g1, e.bcd);
        end
      end
    end
  end

  initial begin
    logic        a, b, r;
    logic [15:0] da, db;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    repeat (2) step(1, 0, 16'h0, 0, 16'h0);
    // single requester, then data change while owned
    repeat (3) step(0, 1, 16'h1234, 0, 16'h0);
    repeat (2) step(0, 1, 16'h5678, 0, 16'h0);
    // return to idle
    repeat (2) step(0, 0, 16'h5678, 0, 16'h0);
    // tie right after reset, then continued contention
    step(1, 0, 16'h0, 0, 16'h0);
    repeat (14) step(0, 1, 16'hAAAA, 1, 16'hBBBB);
    // requester 1 owns, drops early with req0 waiting
    repeat (2) step(0, 0, 16'h0, 0, 16'h0);
    step(0, 0, 16'h0, 1, 16'h9021);
    repeat (2) step(0, 1, 16'h3344, 1, 16'h9021);
    repeat (3) step(0, 1, 16'h3344, 0, 16'h9021);
    // requester 1 owns, req0 rises and contends, then leaves
    repeat (2) step(1, 0, 16'h0, 0, 16'h0);
    repeat (2) step(0, 0, 16'h0, 1, 16'hCDEF);
    repeat (10) step(0, 1, 16'h0246, 1, 16'hCDEF);
    repeat (2) step(0, 0, 16'h0246, 1, 16'hCDEF);
    // reset while requester 1 owns
    step(1, 0, 16'h0, 1, 16'hCDEF);
    step(0, 0, 16'h0, 0, 16'h0);
    // random traffic, requests mostly held so holds expire
    da = 16'h0; db = 16'h0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 79) == 0);
      a = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) da = 16'($urandom);
      if ($urandom_range(0, 3) == 0) db = 16'($urandom);
      step(r, a, da, b, db);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
